// File: rtl/maze_pkg.sv
// Shared constants for the MazeRunner IR line-sensor sweep: FSM encodings,
// channel count, weight table and ADC128S command field layout.
package maze_pkg;

    localparam int          NUM_IR_CH  = 8;
    localparam int          ADC_CH_LSB = 11;
    localparam logic [11:0] NO_REFLECT = 12'hFFF;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETTLE = 3'd1;
    localparam logic [2:0] SEND   = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    // ch0-3 are the right side (inner->outer), ch4-7 the left side
    localparam logic [3:0] IR_WEIGHT [NUM_IR_CH] = '{4'd1, 4'd2, 4'd4, 4'd8,
                                                    4'd1, 4'd2, 4'd4, 4'd8};

    function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
        adc_cmd = 16'(ch) << ADC_CH_LSB;
    endfunction

endpackage

// File: rtl/ir_err_calc.sv
// Weighted line-position error over 8x12b readings, + => line to the right.
// Latency: combinational. Backpressure: none.
module ir_err_calc
    import maze_pkg::*;
(
    input  logic [12*NUM_IR_CH-1:0] readings_i,
    output logic signed [16:0]      line_err_o
);

    logic [16:0] right_sum;
    logic [16:0] left_sum;
    logic [11:0] strength;

    // Each side peaks at 15*4095, so the 17b difference cannot overflow
    always_comb begin
        right_sum = '0;
        left_sum  = '0;
        strength  = '0;
        for (int k = 0; k < NUM_IR_CH; k++) begin
            strength = NO_REFLECT - readings_i[12*k +: 12];
            if (k < NUM_IR_CH/2)
                right_sum = right_sum + 17'(strength) * 17'(IR_WEIGHT[k]);
            else
                left_sum  = left_sum  + 17'(strength) * 17'(IR_WEIGHT[k]);
        end
        line_err_o = $signed(right_sum - left_sum);
    end

endmodule

// File: rtl/ir_sweep_sequencer.sv
// IR sweep sequencer: emitters on, settle, 9 pipelined ADC reads (prime + 8), publish results.
// Latency: SETTLE_CYC+1 cycles to first wrt, one done-handshake per channel, results 2 cycles after last done.
// Backpressure: waits indefinitely on SPI done; strt ignored while busy. Optional IR_ERR_CALC_EN adds line_err.
module ir_sweep_sequencer
    import maze_pkg::*;
#(
    parameter int unsigned SETTLE_CYC     = 4096,
    parameter logic [11:0] PRESENT_THRESH = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        IR_EN,
    output logic        busy,
    output logic        sweep_done,
    output logic [95:0] readings,
    output logic        line_present,
    output logic [16:0] line_err
);

    localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_IR_CH);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             wrt_q, wrt_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             ir_en_q, ir_en_d;
    logic             busy_q, busy_d;
    logic             sweep_done_q, sweep_done_d;
    logic [95:0]      shadow_q, shadow_d;
    logic [95:0]      readings_q, readings_d;
    logic             present_q, present_d;
    logic [16:0]      err_q, err_d;

    logic               shadow_present;
    logic signed [16:0] shadow_err;
    logic               unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

`ifdef IR_ERR_CALC_EN
    ir_err_calc u_err_calc (
        .readings_i (shadow_q),
        .line_err_o (shadow_err)
    );
`else
    assign shadow_err = 17'sd0;
`endif

    always_comb begin
        shadow_present = 1'b0;
        for (int k = 0; k < NUM_IR_CH; k++) begin
            if (shadow_q[12*k +: 12] < PRESENT_THRESH)
                shadow_present = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wrt_d        = 1'b0;
        cmd_d        = cmd_q;
        ir_en_d      = ir_en_q;
        busy_d       = busy_q;
        sweep_done_d = 1'b0;
        shadow_d     = shadow_q;
        readings_d   = readings_q;
        present_d    = present_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (strt) begin
                    state_d = SETTLE;
                    ir_en_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SEND;
                    wrt_d   = 1'b1;
                    cmd_d   = adc_cmd(3'd0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (done) begin
                    // ADC pipeline: each response carries the previous command's channel
                    if (idx_q != 4'd0)
                        shadow_d[12*int'(idx_q - 4'd1) +: 12] = rd_data[11:0];
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = SEND;
                        wrt_d   = 1'b1;
                        cmd_d   = adc_cmd(3'(idx_q + 4'd1));
                    end
                end
            end
            FINISH: begin
                readings_d   = shadow_q;
                present_d    = shadow_present;
                err_d        = shadow_err;
                sweep_done_d = 1'b1;
                ir_en_d      = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            wrt_q        <= 1'b0;
            cmd_q        <= '0;
            ir_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            shadow_q     <= {NUM_IR_CH{NO_REFLECT}};
            readings_q   <= {NUM_IR_CH{NO_REFLECT}};
            present_q    <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wrt_q        <= wrt_d;
            cmd_q        <= cmd_d;
            ir_en_q      <= ir_en_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            shadow_q     <= shadow_d;
            readings_q   <= readings_d;
            present_q    <= present_d;
            err_q        <= err_d;
        end
    end

    assign wrt          = wrt_q;
    assign cmd          = cmd_q;
    assign IR_EN        = ir_en_q;
    assign busy         = busy_q;
    assign sweep_done   = sweep_done_q;
    assign readings     = readings_q;
    assign line_present = present_q;
    assign line_err     = err_q;

endmodule

// File: tb/tb_ir_sweep_sequencer.sv
// Bench for ir_sweep_sequencer: SPI responder, cycle-level behavioural model, per-cycle compare,
// plus literal expectations for reset, timing, pipelined readings, strt/rst corner cases and line_err.
module tb_ir_sweep_sequencer;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = '0;
    logic        wrt, IR_EN, busy, sweep_done, line_present;
    logic [15:0] cmd;
    logic [95:0] readings;
    logic [16:0] line_err;

    always #5 clk = ~clk;

    ir_sweep_sequencer #(.SETTLE_CYC(SETTLE), .PRESENT_THRESH(12'hF00)) dut (
        .clk          (clk),
        .rst          (rst),
        .strt         (strt),
        .wrt          (wrt),
        .cmd          (cmd),
        .done         (done),
        .rd_data      (rd_data),
        .IR_EN        (IR_EN),
        .busy         (busy),
        .sweep_done   (sweep_done),
        .readings     (readings),
        .line_present (line_present),
        .line_err     (line_err)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic [11:0] vals [8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // SPI master stand-in: random 1..4 cycle turnaround, answers with the previous command's channel
    bit          spi_pend = 1'b0;
    int          spi_cnt = 0;
    logic [2:0]  spi_cur = '0;
    logic [2:0]  spi_prev = '0;
    int          spi_wrts = 0;
    int          sd_cnt = 0;
    int          first_wrt_cyc = 0;
    bit          long_lat = 1'b0;

    always @(negedge clk) begin
        done = 1'b0;
        if (spi_pend) begin
            spi_cnt--;
            if (spi_cnt == 0) begin
                done     = 1'b1;
                rd_data  = {4'($urandom_range(0, 15)), vals[spi_prev]};
                spi_prev = spi_cur;
                spi_pend = 1'b0;
            end
        end
        if (wrt) begin
            spi_wrts++;
            if (spi_wrts == 1) first_wrt_cyc = cyc;
            spi_cur  = cmd[13:11];
            spi_pend = 1'b1;
            spi_cnt  = (long_lat && spi_wrts == 4) ? 4 : int'($urandom_range(1, 4));
        end
        if (sweep_done) sd_cnt++;
    end

    // Behavioural model: sweep timeline derived from acceptance edge and done handshakes
    bit          m_busy = 1'b0;
    bit          m_out = 1'b0;
    int          m_dones = 0;
    int          m_fin = -1;
    int          m_accept = -100000;
    bit          e_wrt = 1'b0;
    bit          e_sd = 1'b0;
    logic [2:0]  e_ch = '0;
    logic [95:0] m_rd = {8{12'hFFF}};
    bit          m_lp = 1'b0;
    logic [16:0] m_le17 = '0;

    task automatic publish();
        int le;
        le   = 0;
        m_lp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_rd[12*k +: 12] = vals[k];
            if (vals[k] < 12'hF00) m_lp = 1'b1;
            if (k < 4) le = le + (1 << k) * (4095 - int'(vals[k]));
            else       le = le - (1 << (k - 4)) * (4095 - int'(vals[k]));
        end
`ifdef IR_ERR_CALC_EN
        m_le17 = 17'(le);
`else
        m_le17 = '0;
`endif
    endtask

    always @(posedge clk) begin
        bit wrt_prev;
        cyc++;
        wrt_prev = e_wrt;
        e_wrt    = 1'b0;
        e_sd     = 1'b0;
        if (rst) begin
            m_busy   = 1'b0;
            m_out    = 1'b0;
            m_dones  = 0;
            m_fin    = -1;
            m_accept = -100000;
            m_rd     = {8{12'hFFF}};
            m_lp     = 1'b0;
            m_le17   = '0;
        end else if (m_busy) begin
            if (cyc == m_fin) begin
                m_busy = 1'b0;
                e_sd   = 1'b1;
                publish();
            end else if (wrt_prev) begin
                m_out = 1'b1;
            end else if (m_out && done) begin
                m_out = 1'b0;
                m_dones++;
                if (m_dones == 9) m_fin = cyc + 1;
                else begin
                    e_wrt = 1'b1;
                    e_ch  = 3'(m_dones % 8);
                end
            end
            if (cyc == m_accept + SETTLE) begin
                e_wrt = 1'b1;
                e_ch  = 3'd0;
            end
        end else if (strt) begin
            m_busy   = 1'b1;
            m_accept = cyc;
            m_dones  = 0;
            m_out    = 1'b0;
            m_fin    = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 96'(busy), 96'(m_busy));
            chk("IR_EN", 96'(IR_EN), 96'(m_busy));
            chk("sweep_done", 96'(sweep_done), 96'(e_sd));
            chk("wrt", 96'(wrt), 96'(e_wrt));
            if (e_wrt || m_out) chk("cmd", 96'(cmd), 96'({2'b00, e_ch, 11'h000}));
            chk("readings", readings, m_rd);
            chk("line_present", 96'(line_present), 96'(m_lp));
            chk("line_err", 96'(line_err), 96'(m_le17));
        end
    end

    int c0 = 0;

    task automatic start_sweep();
        @(negedge clk); #1;
        strt     = 1'b1;
        spi_wrts = 0;
        @(negedge clk); #1;
        strt = 1'b0;
        c0   = cyc;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!sweep_done && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        if (!sweep_done) begin
            checks++;
            errors++;
            $display("FAIL %s: no sweep_done, got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic wait_wrts(input int target);
        int n;
        n = 0;
        while (spi_wrts < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        if (spi_wrts < target) begin
            checks++;
            errors++;
            $display("FAIL wait_wrts: got %0d wrt pulses, expected %0d", spi_wrts, target);
        end
    endtask

    task automatic rand_vals();
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       vals[k] = 12'hF00;
                1:       vals[k] = 12'hEFF;
                2:       vals[k] = 12'hFFF;
                default: vals[k] = 12'($urandom_range(0, 4095));
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) vals[k] = 12'hFFF;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_readings", readings, {8{12'hFFF}});
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_line_err", 96'(line_err), 96'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Pipelined readings and start timing
        for (int k = 0; k < 8; k++) vals[k] = 12'(12'hE00 + 16 * k);
        start_sweep();
        chk("ir_en_after_strt", 96'(IR_EN), 96'(1));
        wait_done("t3");
        for (int k = 0; k < 8; k++)
            chk("t3_reading", 96'(readings[12*k +: 12]), 96'(12'hE00 + 16 * k));
        chk("t3_line_present", 96'(line_present), 96'(1));
        chk("t3_wrt_count", 96'(spi_wrts), 96'(9));
        chk("t2_first_wrt_delay", 96'(first_wrt_cyc + 1 - c0), 96'(17));

        // Reset held 3 cycles mid-sweep
        rand_vals();
        start_sweep();
        repeat (30) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("t1_ir_en", 96'(IR_EN), 96'(0));
        chk("t1_busy", 96'(busy), 96'(0));
        chk("t1_readings", readings, {8{12'hFFF}});
        chk("t1_line_err", 96'(line_err), 96'(0));
        @(negedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Reset during WAIT of the 4th transaction; its done lands 2 cycles after release
        long_lat = 1'b1;
        rand_vals();
        start_sweep();
        wait_wrts(4);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1 long_lat = 1'b0;
        chk("t5_idle_after_stale_done", 96'(busy), 96'(0));
        rand_vals();
        start_sweep();
        wait_done("t5");
        chk("t5_wrt_count", 96'(spi_wrts), 96'(9));

        // strt re-pulsed during WAIT
        sd_cnt = 0;
        rand_vals();
        start_sweep();
        wait_wrts(3);
        @(negedge clk); #1;
        strt = 1'b1;
        @(negedge clk); #1;
        strt = 1'b0;
        wait_done("t4");
        repeat (40) @(negedge clk);
        chk("t4_sweep_done_count", 96'(sd_cnt), 96'(1));
        chk("t4_wrt_count", 96'(spi_wrts), 96'(9));

        // Line error corner tables
        for (int k = 0; k < 8; k++) vals[k] = 12'hFFF;
        vals[1] = 12'hE00;
        start_sweep();
        wait_done("t6a");
`ifdef IR_ERR_CALC_EN
        chk("t6_ch1_err", 96'(line_err), 96'(17'd1022));
`else
        chk("t6_ch1_err", 96'(line_err), 96'(0));
`endif
        chk("t6_ch1_present", 96'(line_present), 96'(1));
        vals[1] = 12'hFFF;
        vals[5] = 12'hE00;
        start_sweep();
        wait_done("t6b");
`ifdef IR_ERR_CALC_EN
        chk("t6_ch5_err", 96'(line_err), 96'(17'h1FC02));
`else
        chk("t6_ch5_err", 96'(line_err), 96'(0));
`endif
        vals[5] = 12'hFFF;
        start_sweep();
        wait_done("t6c");
        chk("t6_none_err", 96'(line_err), 96'(0));
        chk("t6_none_present", 96'(line_present), 96'(0));

        // Randomized sweeps around the presence threshold
        for (int i = 0; i < 10; i++) begin
            rand_vals();
            start_sweep();
            wait_done("rand");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // strt held high: back-to-back sweeps
        rand_vals();
        @(negedge clk); #1;
        strt = 1'b1;
        wait_done("held1");
        @(negedge clk); #1;
        chk("held_restart_busy", 96'(busy), 96'(1));
        wait_done("held2");
        strt = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_stopped", 96'(busy), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
